// File: rtl/key_led_sched.sv
// key_led_sched: debounced, latched-mode pattern sequencer owning the 4-LED bank.
// Optional macro KEY_LED_SCHED_PAUSE_EN adds a synchronous 'pause' input that freezes step and timer.
//
// state   | meaning
// IDLE    | LEDs off, step timer held at 0
// RUN_L   | single LED walking toward led[3]
// RUN_R   | single LED walking toward led[0]
// BLINK   | all LEDs on for even steps, off for odd steps
// ALL_ON  | all LEDs on, step timer held at 0
module key_led_sched #(
   parameter logic [19:0] DEB_CNT  = 20'd1_000_000,
   parameter logic [23:0] STEP_CNT = 24'd10_000_000
) (
   input  logic       sys_clk,
   input  logic       sys_rst_n,
   input  logic [3:0] key,
`ifdef KEY_LED_SCHED_PAUSE_EN
   input  logic       pause,
`endif
   output logic [3:0] led,
   output logic [2:0] mode,
   output logic [3:0] key_evt
);

   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] RUN_L  = 3'd1;
   localparam logic [2:0] RUN_R  = 3'd2;
   localparam logic [2:0] BLINK  = 3'd3;
   localparam logic [2:0] ALL_ON = 3'd4;

   logic [3:0]  key_s1;
   logic [3:0]  key_s2;
   logic [3:0]  key_deb;
   logic [19:0] deb_cnt [4];
   logic [3:0]  deb_hit;
   logic [3:0]  deb_fall;
   logic        win_vld;
   logic [2:0]  win_mode;
   logic [2:0]  mode_nxt;
   logic [1:0]  step;
   logic [23:0] step_tmr;
   logic [3:0]  led_nxt;
   logic        run;
   logic        hold;

`ifdef KEY_LED_SCHED_PAUSE_EN
   assign hold = pause;
`else
   assign hold = 1'b0;
`endif

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         key_s1 <= 4'hF;
         key_s2 <= 4'hF;
      end else begin
         key_s1 <= key;
         key_s2 <= key_s1;
      end
   end

   // A bit is accepted on the cycle its counter has seen DEB_CNT consecutive differing samples.
   always_comb begin
      deb_hit = '0;
      for (int i = 0; i < 4; i++) begin
         deb_hit[i] = (key_s2[i] != key_deb[i]) && (deb_cnt[i] == DEB_CNT - 20'd1);
      end
      deb_fall = deb_hit & ~key_s2;
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         key_deb <= 4'hF;
         key_evt <= '0;
         for (int i = 0; i < 4; i++) deb_cnt[i] <= '0;
      end else begin
         key_evt <= deb_fall;
         for (int i = 0; i < 4; i++) begin
            if (key_s2[i] == key_deb[i]) begin
               deb_cnt[i] <= '0;
            end else if (deb_hit[i]) begin
               deb_cnt[i] <= '0;
               key_deb[i] <= key_s2[i];
            end else begin
               deb_cnt[i] <= deb_cnt[i] + 20'd1;
            end
         end
      end
   end

   // Lowest-index press wins; the rest of a simultaneous group is dropped.
   always_comb begin
      win_vld  = |key_evt;
      win_mode = IDLE;
      if      (key_evt[0]) win_mode = RUN_L;
      else if (key_evt[1]) win_mode = RUN_R;
      else if (key_evt[2]) win_mode = BLINK;
      else if (key_evt[3]) win_mode = ALL_ON;
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) mode <= IDLE;
      else            mode <= mode_nxt;
   end

   always_comb begin
      mode_nxt = mode;
      if (win_vld) begin
         mode_nxt = (win_mode == mode) ? IDLE : win_mode;
      end else if (mode > ALL_ON) begin
         mode_nxt = IDLE;
      end
   end

   assign run = (mode == RUN_L) || (mode == RUN_R) || (mode == BLINK);

   // A press takes priority over a coinciding step wrap.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         step     <= '0;
         step_tmr <= '0;
      end else if (win_vld || !run) begin
         step     <= '0;
         step_tmr <= '0;
      end else if (!hold) begin
         if (step_tmr == STEP_CNT - 24'd1) begin
            step_tmr <= '0;
            step     <= step + 2'd1;
         end else begin
            step_tmr <= step_tmr + 24'd1;
         end
      end
   end

   always_comb begin
      led_nxt = 4'b0000;
      case (mode)
         RUN_L:   led_nxt = 4'b0001 << step;
         RUN_R:   led_nxt = 4'b1000 >> step;
         BLINK:   led_nxt = step[0] ? 4'b0000 : 4'b1111;
         ALL_ON:  led_nxt = 4'b1111;
         default: led_nxt = 4'b0000;
      endcase
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) led <= 4'b0000;
      else            led <= led_nxt;
   end

endmodule

// File: tb/tb_key_led_sched.sv
// Randomized bench for key_led_sched against a window/elapsed-time reference model.
`timescale 1ns/1ps
module tb_key_led_sched;

   localparam int DEB_N = 4;
   localparam int STP_N = 8;

   logic       sys_clk   = 1'b0;
   logic       sys_rst_n = 1'b0;
   logic [3:0] key       = 4'hF;
`ifdef KEY_LED_SCHED_PAUSE_EN
   logic       pause     = 1'b0;
`endif
   logic [3:0] led;
   logic [2:0] mode;
   logic [3:0] key_evt;

   int errors = 0;
   int checks = 0;

   // Reference model state: raw key history, debounced levels, mode, running elapsed cycles.
   logic [3:0] m_hist [$];
   logic [3:0] m_deb;
   logic [3:0] m_evt;
   logic [3:0] m_led;
   logic [2:0] m_mode;
   int         m_elapsed;
   int         m_age [4];

   key_led_sched #(.DEB_CNT(20'd4), .STEP_CNT(24'd8)) dut (
      .sys_clk   (sys_clk),
      .sys_rst_n (sys_rst_n),
      .key       (key),
`ifdef KEY_LED_SCHED_PAUSE_EN
      .pause     (pause),
`endif
      .led       (led),
      .mode      (mode),
      .key_evt   (key_evt)
   );

   always #5 sys_clk = ~sys_clk;

   task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [3:0] pattern(input logic [2:0] md, input int st);
      case (md)
         3'd1:    return 4'(1 << st);
         3'd2:    return 4'(8 >> st);
         3'd3:    return (st % 2 == 0) ? 4'hF : 4'h0;
         3'd4:    return 4'hF;
         default: return 4'h0;
      endcase
   endfunction

   task automatic model_reset();
      m_hist.delete();
      for (int i = 0; i < DEB_N + 2; i++) m_hist.push_back(4'hF);
      m_deb = 4'hF;
      m_evt = 4'h0;
      m_led = 4'h0;
      m_mode = 3'd0;
      m_elapsed = 0;
      for (int i = 0; i < 4; i++) m_age[i] = 0;
   endtask

   // Debounced bit flips once the last DEB_N synchronized samples (key delayed by two edges)
   // all disagree with it and all fall after its previous flip.
   task automatic model_edge();
      logic [3:0] n_deb;
      logic [2:0] n_mode;
      logic [2:0] w;
      int         n_el;
      logic       run;
      logic       frz;
      logic       stable;
      m_hist.push_front(key);
      void'(m_hist.pop_back());
      n_deb = m_deb;
      for (int i = 0; i < 4; i++) begin
         stable = 1'b1;
         for (int j = 2; j < DEB_N + 2; j++) if (m_hist[j][i] == m_deb[i]) stable = 1'b0;
         if (stable && m_age[i] >= DEB_N - 1) begin
            n_deb[i] = ~m_deb[i];
            m_age[i] = 0;
         end else begin
            m_age[i]++;
         end
      end
      n_mode = m_mode;
      if (m_evt != 4'h0) begin
         w = m_evt[0] ? 3'd1 : m_evt[1] ? 3'd2 : m_evt[2] ? 3'd3 : 3'd4;
         n_mode = (w == m_mode) ? 3'd0 : w;
      end
      run = (m_mode == 3'd1) || (m_mode == 3'd2) || (m_mode == 3'd3);
      frz = 1'b0;
`ifdef KEY_LED_SCHED_PAUSE_EN
      frz = pause;
`endif
      if (m_evt != 4'h0 || !run) n_el = 0;
      else if (frz)              n_el = m_elapsed;
      else                       n_el = (m_elapsed + 1) % (4 * STP_N);
      m_led     = pattern(m_mode, (m_elapsed / STP_N) % 4);
      m_evt     = m_deb & ~n_deb;
      m_deb     = n_deb;
      m_mode    = n_mode;
      m_elapsed = n_el;
   endtask

   task automatic run_cycles(input logic [3:0] k, input int n);
      for (int c = 0; c < n; c++) begin
         @(negedge sys_clk);
         key = k;
         @(posedge sys_clk);
         model_edge();
         #1;
         check_eq("led",     {4'h0, led},     {4'h0, m_led});
         check_eq("mode",    {5'h0, mode},    {5'h0, m_mode});
         check_eq("key_evt", {4'h0, key_evt}, {4'h0, m_evt});
      end
   endtask

   task automatic do_reset();
      @(negedge sys_clk);
      sys_rst_n = 1'b0;
      model_reset();
      #1;
      check_eq("rst_led",     {4'h0, led},     8'h00);
      check_eq("rst_mode",    {5'h0, mode},    8'h00);
      check_eq("rst_key_evt", {4'h0, key_evt}, 8'h00);
      @(negedge sys_clk);
      sys_rst_n = 1'b1;
   endtask

   function automatic logic [3:0] rand_key();
      int r;
      int a;
      int b;
      r = $urandom_range(0, 9);
      a = $urandom_range(0, 3);
      b = $urandom_range(0, 3);
      if (r < 4)      return 4'hF;
      else if (r < 7) return ~4'(1 << a);
      else if (r < 9) return ~(4'(1 << a) | 4'(1 << b));
      else            return 4'($urandom_range(0, 15));
   endfunction

   initial begin
      model_reset();
      #12;
      do_reset();
      // Directed openers: short glitch, long press into RUN_L, cancel, BLINK, dual press.
      run_cycles(4'hF, 4);
      run_cycles(4'hE, 2);
      run_cycles(4'hF, 10);
      run_cycles(4'hE, 20);
      run_cycles(4'hF, 40);
      run_cycles(4'hE, 10);
      run_cycles(4'hF, 10);
      run_cycles(4'hE, 10);
      run_cycles(4'hF, 15);
      run_cycles(4'hB, 10);
      run_cycles(4'hF, 30);
      run_cycles(4'hB, 10);
      run_cycles(4'hF, 10);
      run_cycles(4'h5, 12);
      run_cycles(4'hF, 30);
      for (int s = 0; s < 160; s++) begin
`ifdef KEY_LED_SCHED_PAUSE_EN
         pause = ($urandom_range(0, 3) == 0);
`endif
         if (s % 50 == 49) do_reset();
         run_cycles(rand_key(), $urandom_range(1, 40));
      end
`ifdef KEY_LED_SCHED_PAUSE_EN
      pause = 1'b0;
`endif
      run_cycles(4'hF, 10);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/key_led_sched.md
Name: key_led_sched

Overview:
- Debounced, latched-mode sequencer for the 4-LED bank, driven by 4 active-low push keys.
- A key press selects a pattern mode. The mode persists after release and is cancelled by pressing the same key again.
- A step timer advances the pattern. Sits between the board keys and the LED pins as the single owner of the LED resource.

Parameters:
- DEB_CNT, 20'd1_000_000, consecutive stable cycles required to accept a key level change (20 ms at 50 MHz)
- STEP_CNT, 24'd10_000_000, cycles per pattern step (0.2 s at 50 MHz); must be >= 2

Ports:
- sys_clk  input  1  system clock
- sys_rst_n  input  1  asynchronous active-low reset
- key  input  4  raw push keys, active-low, asynchronous to sys_clk
- led  output  4  LED drive, 1 = on, registered
- mode  output  3  current mode: 0 IDLE, 1 RUN_L, 2 RUN_R, 3 BLINK, 4 ALL_ON
- key_evt  output  4  one-cycle debounced press pulses, registered

Behaviour:
- Reset: one clock sys_clk; reset is asynchronous, active-low on sys_rst_n. All flops reset asynchronously on sys_rst_n low.
  - led = 4'b0000, mode = 0 (IDLE), key_evt = 4'b0000
  - step = 0, step timer = 0, debounce counters = 0
  - synchronizers and debounced levels = 4'b1111
- Synchronizer: each key bit passes through a 2-flop synchronizer.
- Debounce (per bit):
  - Counter increments while the synced level differs from the debounced level.
  - When the counter reaches DEB_CNT-1, the debounced level takes the synced value and the counter clears.
  - Any cycle where synced equals debounced clears the counter.
- key_evt[i] = 1 for exactly one cycle when debounced[i] goes 1 to 0. No event on release. A held key produces a single event.
- Press arbitration:
  - Multiple key_evt bits in the same cycle: lowest index wins; the others are discarded.
  - The winner maps to: key0 RUN_L, key1 RUN_R, key2 BLINK, key3 ALL_ON.
- Mode FSM, updated at the edge where a winning event is present:
  - Winner equals the current mode: go to IDLE.
  - Otherwise: go to the winner's mode.
  - In both cases step and step timer clear to 0.
- Step timer:
  - Runs only in RUN_L, RUN_R and BLINK. Held at 0 in IDLE and ALL_ON, with step held at 0.
  - Counts 0..STEP_CNT-1, then wraps to 0 and step increments mod 4 (3 to 0).
- Simultaneous events: a press in the same cycle as a step wrap wins; step = 0 and timer = 0.
- led is registered from (mode, step), so it lags mode/step by 1 cycle:
  - IDLE: 0000
  - RUN_L: step 0..3 gives 0001, 0010, 0100, 1000
  - RUN_R: step 0..3 gives 1000, 0100, 0010, 0001
  - BLINK: 1111 on even steps, 0000 on odd steps
  - ALL_ON: 1111
  - Any unused mode encoding gives 0000 and returns the FSM to IDLE.
- Latency: raw key fall to key_evt is 2 sync + DEB_CNT cycles. key_evt to mode is 1 cycle. mode to led is 1 cycle.
- Reset mid-operation: all state returns to reset values immediately. A key held low through reset release is sensed as a new press once debounced.

Optional Feature:
- Macro: KEY_LED_SCHED_PAUSE_EN.
- Defined:
  - Adds input port `pause` (1 bit, active-high, already synchronous to sys_clk).
  - While pause = 1, the step timer and step hold their values; led holds its current pattern.
  - Key events and mode changes still act normally, including clearing step and timer.
- Undefined: no pause port; the timer always runs in RUN_L, RUN_R and BLINK.

Test Plan (DEB_CNT=4, STEP_CNT=8):
- Reset with keys high: led=0000, mode=0, key_evt=0000. Hold key0 low 2 cycles then release: no key_evt, mode stays 0.
- Hold key0 low for 20 cycles: exactly one key_evt[0] pulse; mode=1; led goes 0001, 0010, 0100, 1000, 0001 at 8-cycle intervals.
- In RUN_L, press key0 again: mode=0; led=0000 one cycle later; timer frozen at 0.
- In RUN_L at step 2, press key2: mode=3, step=0; led=1111 for 8 cycles, then 0000.
- Drop key1 and key3 low on the same cycle from IDLE: key_evt=1010, mode=2, led=1000.
- Time a press so key_evt coincides with the timer at 7 in RUN_R: step becomes 0, not incremented. With KEY_LED_SCHED_PAUSE_EN defined, pause=1 for 30 cycles holds led unchanged.
